mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-002 The module SHALL expose exactly these ports:
  clk  in  1  rising-edge clock
  rst_n  in  1  async active-low reset
  validm  in  1  M-stage slot holds a live instruction
  aluoutm  in  32  effective byte address from EX/MEM register
  writedatam  in  32  store data, right-justified
  memtoregm  in  1  load
  memwritem  in  1  store; loads have priority if both set
  memsizem  in  2  00 byte, 01 half, 10/11 word
  memsignedm  in  1  sign-extend load result
  rdm  out  32  formatted load data toward WB register
  stallm  out  1  hold all upstream stages and the WB register input
  misalign_exc  out  1  misaligned-access exception pulse
  dmem_req  out  1  bus request, registered
  dmem_we  out  1  bus write enable, registered
  dmem_addr  out  32  word-aligned bus address, registered
  dmem_be  out  4  byte enables, bit i = byte lane i
  dmem_wdata  out  32  lane-replicated store data, registered
  dmem_rdata  in  32  bus read data, valid with ack
  dmem_ack  in  1  one-cycle transfer completion

Function
REQ-003 Access condition SHALL be validm & (memtoregm | memwritem); otherwise pass-through: stallm=0, rdm=0, no bus activity.
REQ-004 FSM SHALL have states IDLE, BUSY, DONE.
REQ-005 IDLE with access (aligned): stallm=1 combinationally; at the next edge latch addr/we/be/wdata/size/sign and enter BUSY.
REQ-006 BUSY: dmem_req=1, stallm=1; address, we, be and wdata SHALL stay stable until the ack cycle.
REQ-007 BUSY & dmem_ack: capture formatted dmem_rdata (loads) into rdata register, drop dmem_req at the same edge, enter DONE.
REQ-008 DONE: stallm=0, rdm=rdata register (0 for stores); unconditional return to IDLE at the next edge, so the held instruction is never reissued.
REQ-009 Minimum access latency SHALL be 3 cycles (IDLE, BUSY, DONE) with ack in the first BUSY cycle; each extra wait cycle adds one.
REQ-010 dmem_ack outside BUSY SHALL be ignored.
REQ-011 Byte enables: byte 0001<<a[1:0]; half 0011<<(2*a[1]); word 1111. dmem_addr = {a[31:2],2'b00}.
REQ-012 Store data: byte replicated x4, half replicated x2, word unchanged.
REQ-013 Load extract SHALL use the lane selected by a[1:0]; byte/half zero- or sign-extended per memsignedm to 32 bits.
REQ-014 Misaligned: half with a[0]=1; word with a[1:0]!=00; bytes never misaligned.

Reset
REQ-015 rst_n low SHALL force IDLE immediately, with dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, rdata register=0, misalign_exc=0; stallm and rdm then follow IDLE rules.
REQ-016 Reset during BUSY SHALL abandon the transfer; a late ack after release SHALL be ignored.

Configuration
REQ-017 With MEM_MISALIGN_EXC_EN defined: a misaligned access in IDLE SHALL raise misalign_exc for that single cycle, keep stallm=0 and rdm=0, issue no bus request, and stay in IDLE.
REQ-018 Without MEM_MISALIGN_EXC_EN: misalign_exc SHALL be tied 0; the offending low address bits are cleared (half a[0]=0, word a[1:0]=00) and the access proceeds normally.

Verification
REQ-019 Word store a=0x100, data 0x11223344, ack after 2 BUSY cycles -> dmem_addr=0x100, be=1111, we=1, stallm high 3 cycles, DONE then IDLE.
REQ-020 Byte load a=0x203, signed, memory word 0x80FFFFFF -> be=1000, rdm=0xFFFFFF80 in DONE; unsigned same access -> rdm=0x00000080.
REQ-021 Half store a=0x42, data 0x0000BEEF -> dmem_addr=0x40, be=1100, dmem_wdata=0xBEEFBEEF.
REQ-022 Word load a=0x105: with macro -> misalign_exc one-cycle pulse, dmem_req never high; without macro -> dmem_addr=0x104, normal load.
REQ-023 rst_n low during BUSY, then ack pulse after release -> dmem_req=0 at once, state IDLE, rdm=0, ack ignored.
REQ-024 Spurious dmem_ack in IDLE with validm=0 -> no state change, stallm=0, rdm=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: one outstanding data-bus access, IDLE -> BUSY -> DONE handshake.
// Optional `MEM_MISALIGN_EXC_EN` turns misaligned accesses into an exception pulse.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        validm,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  input  logic        memtoregm,
  input  logic        memwritem,
  input  logic [1:0]  memsizem,
  input  logic        memsignedm,
  output logic [31:0] rdm,
  output logic        stallm,
  output logic        misalign_exc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic        access, start;
  logic [31:0] addr_eff;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        req_q, we_q, sign_q, load_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] lane_data, load_fmt;

  assign access = validm & (memtoregm | memwritem);

`ifdef MEM_MISALIGN_EXC_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    if (memsizem == 2'b01)  misalign = aluoutm[0];
    else if (memsizem[1])   misalign = |aluoutm[1:0];
  end
  assign addr_eff     = aluoutm;
  assign start        = (state_q == IDLE) & access & ~misalign;
  // Gated by rst_n so the pulse cannot appear while reset holds the FSM in IDLE.
  assign misalign_exc = rst_n & (state_q == IDLE) & access & misalign;
`else
  // Offending low address bits are dropped and the access proceeds.
  always_comb begin
    addr_eff = aluoutm;
    if (memsizem == 2'b01) addr_eff[0]   = 1'b0;
    else if (memsizem[1])  addr_eff[1:0] = 2'b00;
  end
  assign start        = (state_q == IDLE) & access;
  assign misalign_exc = 1'b0;
`endif

  always_comb begin
    case (memsizem)
      2'b00:   begin be_d = 4'b0001 << addr_eff[1:0];        wdata_d = {4{writedatam[7:0]}};  end
      2'b01:   begin be_d = 4'b0011 << {addr_eff[1], 1'b0};  wdata_d = {2{writedatam[15:0]}}; end
      default: begin be_d = 4'b1111;                         wdata_d = writedatam;            end
    endcase
  end

  assign lane_data = dmem_rdata >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_fmt = {{24{sign_q & lane_data[7]}},  lane_data[7:0]};
      2'b01:   load_fmt = {{16{sign_q & lane_data[15]}}, lane_data[15:0]};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stallm  = 1'b0;
    rdm     = '0;
    case (state_q)
      IDLE: if (start) begin
        stallm  = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        stallm = 1'b1;
        if (dmem_ack) state_d = DONE;
      end
      DONE: begin
        rdm     = rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      lane_q  <= '0;
      sign_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= memwritem & ~memtoregm;
        addr_q  <= {addr_eff[31:2], 2'b00};
        be_q    <= be_d;
        wdata_q <= wdata_d;
        size_q  <= memsizem;
        lane_q  <= addr_eff[1:0];
        sign_q  <= memsignedm;
        load_q  <= memtoregm;
      end else if ((state_q == BUSY) && dmem_ack) begin
        req_q   <= 1'b0;
        we_q    <= 1'b0;
        rdata_q <= load_q ? load_fmt : '0;
      end
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected bus/load results queued at issue, compared when the DUT responds.
module tb_mem_stage;

  logic        clk, rst_n;
  logic        validm, memtoregm, memwritem, memsignedm;
  logic [31:0] aluoutm, writedatam;
  logic [1:0]  memsizem;
  logic [31:0] rdm;
  logic        stallm, misalign_exc;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdm;
  } exp_t;

  exp_t sbq[$];

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .validm(validm), .aluoutm(aluoutm),
    .writedatam(writedatam), .memtoregm(memtoregm), .memwritem(memwritem),
    .memsizem(memsizem), .memsignedm(memsignedm), .rdm(rdm), .stallm(stallm),
    .misalign_exc(misalign_exc), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword);
    exp_t        e;
    logic [31:0] ea;
    logic [7:0]  b;
    logic [15:0] h;
    ea = a;
    if (sz == 2'b01) ea[0] = 1'b0;
    if (sz[1])       ea[1:0] = 2'b00;
    e.addr = {ea[31:2], 2'b00};
    e.we   = st & ~ld;
    case (sz)
      2'b00: begin
        case (ea[1:0])
          2'd0: e.be = 4'b0001;
          2'd1: e.be = 4'b0010;
          2'd2: e.be = 4'b0100;
          default: e.be = 4'b1000;
        endcase
        e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      end
      2'b01: begin
        e.be    = ea[1] ? 4'b1100 : 4'b0011;
        e.wdata = {wd[15:0], wd[15:0]};
      end
      default: begin
        e.be    = 4'b1111;
        e.wdata = wd;
      end
    endcase
    b = rword[8*ea[1:0] +: 8];
    h = rword[16*ea[1] +: 16];
    if (!ld)              e.rdm = 32'h0;
    else if (sz == 2'b00) e.rdm = (sg && b[7])  ? {24'hFFFFFF, b} : {24'h0, b};
    else if (sz == 2'b01) e.rdm = (sg && h[15]) ? {16'hFFFF, h}   : {16'h0, h};
    else                  e.rdm = rword;
    return e;
  endfunction

  // One complete access: IDLE cycle, nwait extra BUSY cycles, ack, DONE, back to IDLE.
  task automatic run_access(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                            input int unsigned nwait, input bit spur);
    exp_t        got;
    int unsigned stalls;
    got = '{default: '0};
    sbq.push_back(model(ld, st, sz, sg, a, wd, rword));
    @(negedge clk);
    validm = 1'b1; memtoregm = ld; memwritem = st; memsizem = sz; memsignedm = sg;
    aluoutm = a; writedatam = wd; dmem_ack = spur; dmem_rdata = 32'hDEADBEEF;
    #1;
    check("idle_stall", stallm, 1'b1);
    check("idle_req", dmem_req, 1'b0);
    check("idle_exc", misalign_exc, 1'b0);
    stalls = 1;
    for (int i = 0; i <= int'(nwait); i++) begin
      @(negedge clk);
      dmem_ack   = (i == int'(nwait));
      dmem_rdata = (i == int'(nwait)) ? rword : 32'h0;
      #1;
      if (i == 0) begin
        checks++;
        assert (sbq.size() != 0) else begin
          errors++;
          $error("FAIL sb_empty: observed=%0d expected=%0d", sbq.size(), 1);
        end
        if (sbq.size() != 0) got = sbq.pop_front();
      end
      check("busy_req", dmem_req, 1'b1);
      check("busy_addr", dmem_addr, got.addr);
      check("busy_be", {28'h0, dmem_be}, {28'h0, got.be});
      check("busy_we", dmem_we, got.we);
      check("busy_wdata", dmem_wdata, got.wdata);
      if (stallm) stalls++;
    end
    @(negedge clk);
    dmem_ack = 1'b0; validm = 1'b0; memtoregm = 1'b0; memwritem = 1'b0;
    #1;
    check("done_stall", stallm, 1'b0);
    check("done_req", dmem_req, 1'b0);
    check("done_rdm", rdm, got.rdm);
    check("stall_cycles", stalls, nwait + 2);
    @(negedge clk);
    #1;
    check("post_stall", stallm, 1'b0);
    check("post_rdm", rdm, 32'h0);
    check("post_req", dmem_req, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; validm = 1'b0; memtoregm = 1'b0; memwritem = 1'b0; memsignedm = 1'b0;
    memsizem = 2'b00; aluoutm = '0; writedatam = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", dmem_req, 1'b0);
    check("rst_we", dmem_we, 1'b0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_be", {28'h0, dmem_be}, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_stall", stallm, 1'b0);
    check("rst_rdm", rdm, 32'h0);
    check("rst_exc", misalign_exc, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Word store, ack on second BUSY cycle
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 32'h0, 1, 1'b0);
    // Byte load lane 3, signed then unsigned
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FFFFFF, 0, 1'b0);
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FFFFFF, 0, 1'b0);
    // Half store upper lane
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h42, 32'h0000BEEF, 32'h0, 0, 1'b0);
    // Byte store lane 1, half loads, word load with long wait, load+store priority
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h1001, 32'h000000A5, 32'h0, 2, 1'b0);
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h300, 32'h0, 32'h1234F00D, 0, 1'b0);
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 32'h9ABC0000, 1, 1'b0);
    run_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 32'hCAFEF00D, 3, 1'b0);
    run_access(1'b1, 1'b1, 2'b10, 1'b1, 32'h500, 32'hFFFFFFFF, 32'h76543210, 0, 1'b0);
    // Ack asserted during the IDLE cycle must not shortcut the transfer
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h602, 32'h0, 32'h00450000, 0, 1'b1);

`ifdef MEM_MISALIGN_EXC_EN
    @(negedge clk);
    validm = 1'b1; memtoregm = 1'b1; memsizem = 2'b10; aluoutm = 32'h105;
    #1;
    check("mis_exc", misalign_exc, 1'b1);
    check("mis_stall", stallm, 1'b0);
    check("mis_rdm", rdm, 32'h0);
    @(negedge clk);
    validm = 1'b0; memtoregm = 1'b0;
    #1;
    check("mis_exc_pulse", misalign_exc, 1'b0);
    check("mis_req", dmem_req, 1'b0);
    @(negedge clk);
    #1;
    check("mis_req2", dmem_req, 1'b0);
    check("mis_stall2", stallm, 1'b0);
`else
    // Misaligned word and half loads proceed with cleared low address bits
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h105, 32'h0, 32'h5A5A1234, 0, 1'b0);
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h703, 32'h0, 32'h8001FFFF, 0, 1'b0);
`endif

    // Reset while BUSY, then a late ack after release
    @(negedge clk);
    validm = 1'b1; memwritem = 1'b1; memsizem = 2'b10; aluoutm = 32'h300; writedatam = 32'h0BADF00D;
    #1;
    check("rb_idle_stall", stallm, 1'b1);
    @(negedge clk);
    #1;
    check("rb_busy_req", dmem_req, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; validm = 1'b0; memwritem = 1'b0;
    #1;
    check("rb_req", dmem_req, 1'b0);
    check("rb_we", dmem_we, 1'b0);
    check("rb_addr", dmem_addr, 32'h0);
    check("rb_wdata", dmem_wdata, 32'h0);
    check("rb_stall", stallm, 1'b0);
    check("rb_rdm", rdm, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    check("late_ack_stall", stallm, 1'b0);
    @(negedge clk); dmem_ack = 1'b0;
    #1;
    check("late_ack_rdm", rdm, 32'h0);
    check("late_ack_req", dmem_req, 1'b0);
    check("late_ack_stall2", stallm, 1'b0);

    // Spurious ack in IDLE with no valid instruction, load flag set
    @(negedge clk);
    dmem_ack = 1'b1; memtoregm = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    check("spur_stall", stallm, 1'b0);
    check("spur_rdm", rdm, 32'h0);
    @(negedge clk);
    dmem_ack = 1'b0; memtoregm = 1'b0;
    #1;
    check("spur_req", dmem_req, 1'b0);
    check("spur_stall2", stallm, 1'b0);
    check("spur_rdm2", rdm, 32'h0);
    check("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
